// File: rtl/regfile_dump.sv
// regfile_dump: sweeps the register file test port and streams every word
// out over a valid/ready interface for a UART or trace sink.
// Optional feature macro: REGFILE_DUMP_CHECKSUM_EN appends an XOR checksum
// word after the last register.
module regfile_dump #(
    parameter int unsigned NREG   = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] test_addr,
    input  logic [DATA_W-1:0] test_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
`ifdef REGFILE_DUMP_CHECKSUM_EN
        ST_SUM   = 3'd3,
`endif
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic                out_last_q, out_last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   acc_q, acc_d;
`endif

    // Next-state and registered-output logic for the sweep.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        acc_d       = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    busy_d  = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    acc_d   = '0;
`endif
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Snapshot of the register is taken here, not at send time.
                out_data_d  = test_data;
                out_addr_d  = idx_q;
                out_valid_d = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                out_last_d  = 1'b0;
                acc_d       = acc_q ^ test_data;
`else
                out_last_d  = (idx_q == LAST_IDX);
`endif
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (idx_q == LAST_IDX) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        // Present the checksum word straight away.
                        out_valid_d = 1'b1;
                        out_data_d  = acc_q;
                        out_addr_d  = '0;
                        out_last_d  = 1'b1;
                        state_d     = ST_SUM;
`else
                        state_d     = ST_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            ST_SUM: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign test_addr = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: a vector table of full dumps under
// varying backpressure plus hand sequences for start filtering, mid-dump
// reset and regfile writes during a dump. Honours REGFILE_DUMP_CHECKSUM_EN.
module tb_regfile_dump;

    localparam int unsigned NREG   = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif
    localparam int NWORDS  = int'(NREG) + (CKS ? 1 : 0);
    localparam int EXP_LAT = 2 * int'(NREG) + 1 + (CKS ? 1 : 0);

    logic              clk;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] test_addr;
    logic [DATA_W-1:0] test_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
    } word_t;

    typedef struct {
        string       name;
        int          pct;
        logic [31:0] base;
        int          exp_lat;
    } vec_t;

    logic [DATA_W-1:0] rf     [NREG];
    logic [DATA_W-1:0] exp_rf [NREG];
    word_t             got [$];
    word_t             held;
    logic              prev_stall;
    int                stall_err;
    int                done_cnt;
    int                cyc;
    int                start_cyc;
    int                pct;
    int                n_vec;
    int                n_bad;

    regfile_dump #(.NREG(NREG), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .test_addr (test_addr),
        .test_data (test_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last)
    );

    assign test_data = rf[test_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record accepted words, stalls that change, and done pulses.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!out_valid || out_data != held.data ||
                               out_addr != held.addr || out_last != held.last))
                stall_err <= stall_err + 1;
            if (out_valid && out_ready)
                got.push_back('{addr: out_addr, data: out_data, last: out_last});
            prev_stall <= out_valid && !out_ready;
            held       <= '{addr: out_addr, data: out_data, last: out_last};
            if (done)
                done_cnt <= done_cnt + 1;
        end
    end

    // Sink readiness, redrawn every cycle from the current percentage.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (int'($urandom_range(0, 99)) < pct);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] base);
        for (int i = 0; i < int'(NREG); i++) begin
            rf[i]     = (i == 0) ? '0 : base + DATA_W'(i);
            exp_rf[i] = rf[i];
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int c = 0; c < 4000 && !seen; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat  = cyc - start_cyc;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_word(input string tag, input logic [ADDR_W-1:0] a);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (out_valid && out_addr == a) seen = 1'b1;
        end
        check({tag, "_reach_addr"}, 64'(seen), 64'd1);
    endtask

    task automatic check_words(input string tag, input int base);
        logic [DATA_W-1:0] x;
        word_t             e;
        int                n;
        x = '0;
        n = got.size() - base;
        check({tag, "_count"}, 64'(n), 64'(NWORDS));
        for (int i = 0; i < NWORDS && i < n; i++) begin
            if (i < int'(NREG)) begin
                e.addr = ADDR_W'(i);
                e.data = exp_rf[i];
                e.last = !CKS && (i == int'(NREG) - 1);
                x      = x ^ exp_rf[i];
            end else begin
                e.addr = '0;
                e.data = x;
                e.last = 1'b1;
            end
            check($sformatf("%s_addr[%0d]", tag, i), 64'(got[base+i].addr), 64'(e.addr));
            check($sformatf("%s_data[%0d]", tag, i), 64'(got[base+i].data), 64'(e.data));
            check($sformatf("%s_last[%0d]", tag, i), 64'(got[base+i].last), 64'(e.last));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_done"},      64'(done),      64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_last"},  64'(out_last),  64'd0);
        check({tag, "_out_data"},  64'(out_data),  64'd0);
        check({tag, "_out_addr"},  64'(out_addr),  64'd0);
        check({tag, "_test_addr"}, 64'(test_addr), 64'd0);
    endtask

    initial begin
        vec_t vecs[4];
        int   base;
        int   dbase;
        int   sbase;
        int   lat;

        vecs[0] = '{name: "full_rate", pct: 100, base: 32'h1000_0000, exp_lat: EXP_LAT};
        vecs[1] = '{name: "bp30",      pct: 30,  base: 32'hA5A5_0000, exp_lat: 0};
        vecs[2] = '{name: "bp70",      pct: 70,  base: 32'h0123_4500, exp_lat: 0};
        vecs[3] = '{name: "bp10",      pct: 10,  base: 32'h7FFF_FFF0, exp_lat: 0};

        n_vec = 0; n_bad = 0; cyc = 0; start_cyc = 0;
        stall_err = 0; done_cnt = 0; prev_stall = 1'b0; held = '0;
        pct = 100; start = 1'b0; reset = 1'b1;
        preload(32'h1000_0000);

        repeat (3) @(posedge clk);
        #2;
        check_idle("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        // Table-driven full dumps.
        foreach (vecs[v]) begin
            pct = vecs[v].pct;
            preload(vecs[v].base);
            base  = got.size();
            sbase = stall_err;
            pulse_start();
            @(negedge clk);
            check({vecs[v].name, "_busy_after_start"}, 64'(busy), 64'd1);
            wait_done(vecs[v].name, lat);
            if (vecs[v].exp_lat != 0)
                check({vecs[v].name, "_latency"}, 64'(lat), 64'(vecs[v].exp_lat));
            check({vecs[v].name, "_busy_at_done"}, 64'(busy), 64'd0);
            @(negedge clk);
            check({vecs[v].name, "_done_one_cycle"}, 64'(done), 64'd0);
            check_words(vecs[v].name, base);
            check({vecs[v].name, "_stall_stable"}, 64'(stall_err - sbase), 64'd0);
        end

        // Start pulses while busy and during the DONE cycle are ignored.
        pct = 100;
        preload(32'h2000_0000);
        base  = got.size();
        dbase = done_cnt;
        pulse_start();
        for (int c = 1; c <= EXP_LAT + 10; c++) begin
            @(posedge clk);
            #1;
            start = (c >= 4 && c < EXP_LAT);
        end
        start = 1'b0;
        @(negedge clk);
        check("ignore_start_busy", 64'(busy), 64'd0);
        check("ignore_start_valid", 64'(out_valid), 64'd0);
        check("ignore_start_dones", 64'(done_cnt - dbase), 64'd1);
        check_words("ignore_start", base);

        // Asynchronous reset while word 10 is stalled in SEND.
        pct = 100;
        preload(32'h3000_0000);
        pulse_start();
        wait_word("rst", ADDR_W'(9));
        pct = 0;
        wait_word("rst", ADDR_W'(10));
        #2;
        reset = 1'b1;
        #1;
        check_idle("mid_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pct = 100;
        base = got.size();
        pulse_start();
        wait_done("after_rst", lat);
        check("after_rst_latency", 64'(lat), 64'(EXP_LAT));
        check_words("after_rst", base);

        // Regfile writes during a dump: only unfetched addresses change.
        pct = 100;
        preload(32'h1000_0000);
        base = got.size();
        pulse_start();
        wait_word("wr", ADDR_W'(2));
        rf[5]     = 32'hDEAD_BEEF;
        exp_rf[5] = 32'hDEAD_BEEF;
        wait_word("wr", ADDR_W'(3));
        rf[1] = 32'h0000_0001;
        wait_done("wr", lat);
        check_words("wr", base);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
